// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch core: FSM state encoding and BCD digit helpers.
package stopwatch_pkg;

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Non-decimal nibbles on the preset switches are treated as 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD digit of the count chain: steps up or down when enabled and reports
// carry (up) or borrow (down) to the next digit.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] i_d,
  input  logic             i_en,
  input  logic             i_dir,
  output logic [BCD_W-1:0] o_d,
  output logic             o_co
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    o_d  = i_d;
    o_co = 1'b0;
    if (i_en) begin
      if (i_dir) begin
        if (i_d == '0) begin
          o_d  = BCD_MAX;
          o_co = 1'b1;
        end else begin
          o_d = i_d - 1'b1;
        end
      end else begin
        if (i_d >= BCD_MAX) begin
          o_d  = '0;
          o_co = 1'b1;
        end else begin
          o_d = i_d + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// N-digit BCD stopwatch/timer: button edge detect, run/stop/done FSM, tick
// prescaler, ripple BCD count chain, preset load and lap hold.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int NDIG    = 4,
  parameter int CLK_DIV = 1000,
  parameter int DIV_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  inc,
  input  logic                  lap,
  input  logic                  load,
  input  logic                  down,
  input  logic [BCD_W*NDIG-1:0] preset,
  output logic [BCD_W*NDIG-1:0] cntr,
  output logic                  running,
  output logic                  lap_active,
  output logic                  expired
);

  localparam int CW = BCD_W * NDIG;

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_presc;
  logic             r_start_q, r_stop_q, r_inc_q, r_lap_q, r_load_q;
  logic [CW-1:0]    r_count, r_lap_reg;
  logic             r_lap_active, r_running, r_expired;

  logic             w_start_rise, w_stop_rise, w_inc_rise, w_lap_rise, w_load_rise;
  logic             w_tick, w_zero, w_one, w_underflow;
  logic [1:0]       w_state_d;
  logic             w_step, w_do_load, w_expire;
  logic [CW-1:0]    w_next, w_count_d, w_preset_c;
  logic [NDIG:0]    w_carry;

  assign w_start_rise = start & ~r_start_q;
  assign w_stop_rise  = stop  & ~r_stop_q;
  assign w_inc_rise   = inc   & ~r_inc_q;
  assign w_lap_rise   = lap   & ~r_lap_q;
  assign w_load_rise  = load  & ~r_load_q;

  assign w_tick = (r_state == ST_RUN) && (r_presc == DIV_W'(CLK_DIV - 1));
  assign w_zero = (r_count == '0);
  assign w_one  = (r_count == CW'(1));

  assign w_carry[0] = w_step;
  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit u_digit (
      .i_d  (r_count[g*BCD_W +: BCD_W]),
      .i_en (w_carry[g]),
      .i_dir(down),
      .o_d  (w_next[g*BCD_W +: BCD_W]),
      .o_co (w_carry[g+1])
    );
    assign w_preset_c[g*BCD_W +: BCD_W] = bcd_clamp(preset[g*BCD_W +: BCD_W]);
  end

  // A borrow out of the top digit means a down-step from all zeros: hold at zero.
  assign w_underflow = down & w_carry[NDIG];
  assign w_count_d   = w_underflow ? r_count : w_next;

  always_comb begin
    w_state_d = r_state;
    w_step    = 1'b0;
    w_do_load = 1'b0;
    w_expire  = 1'b0;
    case (r_state)
      ST_STOP: begin
        if (w_stop_rise) begin
          w_state_d = ST_STOP;
        end else if (w_start_rise) begin
          if (down && w_zero) begin
            w_state_d = ST_DONE;
            w_expire  = 1'b1;
          end else begin
            w_state_d = ST_RUN;
          end
        end else if (w_load_rise) begin
          w_do_load = 1'b1;
        end else if (w_inc_rise) begin
          w_step = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_stop_rise) begin
          w_state_d = ST_STOP;
        end else if (w_tick) begin
          w_step = 1'b1;
          if (down && (w_one || w_zero)) begin
            w_state_d = ST_DONE;
            w_expire  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (w_load_rise) begin
          w_do_load = 1'b1;
          w_state_d = ST_STOP;
        end else if (w_start_rise && !w_stop_rise && !down) begin
          w_state_d = ST_RUN;
        end
      end
      default: w_state_d = ST_STOP;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_STOP;
      r_presc      <= '0;
      r_start_q    <= 1'b0;
      r_stop_q     <= 1'b0;
      r_inc_q      <= 1'b0;
      r_lap_q      <= 1'b0;
      r_load_q     <= 1'b0;
      r_count      <= '0;
      r_lap_reg    <= '0;
      r_lap_active <= 1'b0;
      r_running    <= 1'b0;
      r_expired    <= 1'b0;
    end else begin
      r_start_q <= start;
      r_stop_q  <= stop;
      r_inc_q   <= inc;
      r_lap_q   <= lap;
      r_load_q  <= load;
      r_state   <= w_state_d;
      r_running <= (w_state_d == ST_RUN);
      r_expired <= w_expire;
      r_presc   <= (r_state == ST_RUN && w_state_d == ST_RUN && !w_tick) ?
                   r_presc + 1'b1 : '0;
      if (w_do_load) begin
        r_count <= w_preset_c;
      end else if (w_step) begin
        r_count <= w_count_d;
      end
      if (w_lap_rise) begin
        if (r_lap_active) begin
          r_lap_active <= 1'b0;
        end else begin
          r_lap_reg    <= r_count;
          r_lap_active <= 1'b1;
        end
      end
      // A preset load releases any lap hold so the new value is visible.
      if (w_do_load) begin
        r_lap_active <= 1'b0;
      end
    end
  end

  assign cntr       = r_lap_active ? r_lap_reg : r_count;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign expired    = r_expired;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core (NDIG=4, CLK_DIV=4): a vector table
// plus hand-written multi-cycle sequences, all through one scoreboard queue.
module tb_stopwatch_core;

  typedef struct {
    string       name;
    logic        start, stop, inc, lap, load, down;
    logic [15:0] preset;
    logic [15:0] e_cntr;
    logic [2:0]  e_flags;  // {running, lap_active, expired}
  } vec_t;

  logic        clk, rst;
  logic        start, stop, inc, lap, load, down;
  logic [15:0] preset;
  logic [15:0] cntr;
  logic        running, lap_active, expired;

  int n_chk = 0;
  int n_err = 0;
  vec_t sb_q[$];
  vec_t tbl[$];

  stopwatch_core #(.NDIG(4), .CLK_DIV(4), .DIV_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .inc       (inc),
    .lap       (lap),
    .load      (load),
    .down      (down),
    .preset    (preset),
    .cntr      (cntr),
    .running   (running),
    .lap_active(lap_active),
    .expired   (expired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [5:0] btn, input logic [15:0] pre,
                              input logic [15:0] c, input logic [2:0] f);
    vec_t v;
    v.name   = n;
    v.start  = btn[5];
    v.stop   = btn[4];
    v.inc    = btn[3];
    v.lap    = btn[2];
    v.load   = btn[1];
    v.down   = btn[0];
    v.preset = pre;
    v.e_cntr = c;
    v.e_flags = f;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    start  = v.start;
    stop   = v.stop;
    inc    = v.inc;
    lap    = v.lap;
    load   = v.load;
    down   = v.down;
    preset = v.preset;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.name, "_cntr"}, 32'(cntr), 32'(e.e_cntr));
    check({e.name, "_flags"}, 32'({running, lap_active, expired}), 32'(e.e_flags));
  endtask

  task automatic run(input string n, input logic [5:0] btn, input logic [15:0] pre,
                     input logic [15:0] c, input logic [2:0] f);
    apply(mk(n, btn, pre, c, f));
  endtask

  initial begin
    rst = 1'b1;
    {start, stop, inc, lap, load, down} = '0;
    preset = '0;
    #1;
    check("reset_cntr", 32'(cntr), 32'h0);
    check("reset_flags", 32'({running, lap_active, expired}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // btn = {start, stop, inc, lap, load, down}; flags = {running, lap_active, expired}
    tbl.push_back(mk("idle",      6'b000000, 16'h0000, 16'h0000, 3'b000));
    tbl.push_back(mk("load9",     6'b000010, 16'h0009, 16'h0009, 3'b000));
    tbl.push_back(mk("inc_up",    6'b001000, 16'h0000, 16'h0010, 3'b000));
    tbl.push_back(mk("idle2",     6'b000000, 16'h0000, 16'h0010, 3'b000));
    tbl.push_back(mk("inc_dn",    6'b001001, 16'h0000, 16'h0009, 3'b000));
    tbl.push_back(mk("load0",     6'b000010, 16'h0000, 16'h0000, 3'b000));
    tbl.push_back(mk("inc_dn0",   6'b001001, 16'h0000, 16'h0000, 3'b000));
    tbl.push_back(mk("clamp",     6'b000010, 16'hA3F1, 16'h9391, 3'b000));
    tbl.push_back(mk("start_stop",6'b110000, 16'h0000, 16'h9391, 3'b000));
    tbl.push_back(mk("idle3",     6'b000000, 16'h0000, 16'h9391, 3'b000));
    tbl.push_back(mk("start",     6'b100000, 16'h0000, 16'h9391, 3'b100));
    tbl.push_back(mk("inc_run",   6'b001000, 16'h0000, 16'h9391, 3'b100));
    tbl.push_back(mk("load_run",  6'b000010, 16'h0000, 16'h9391, 3'b100));
    tbl.push_back(mk("wait",      6'b000000, 16'h0000, 16'h9391, 3'b100));
    tbl.push_back(mk("tick1",     6'b000000, 16'h0000, 16'h9392, 3'b100));
    tbl.push_back(mk("stop",      6'b010000, 16'h0000, 16'h9392, 3'b000));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Up-count: one tick every 4 cycles after the start edge.
    run("up_load", 6'b000010, 16'h0000, 16'h0000, 3'b000);
    run("up_start", 6'b100000, 16'h0000, 16'h0000, 3'b100);
    for (int i = 1; i <= 40; i++) run("up", 6'b000000, 16'h0000, to_bcd(i / 4), 3'b100);
    run("up_stop", 6'b010000, 16'h0000, 16'h0010, 3'b000);

    // Wrap from 9999 keeps running.
    run("wrap_load", 6'b000010, 16'h9999, 16'h9999, 3'b000);
    run("wrap_start", 6'b100000, 16'h0000, 16'h9999, 3'b100);
    for (int i = 1; i <= 4; i++)
      run("wrap", 6'b000000, 16'h0000, (i < 4) ? 16'h9999 : 16'h0000, 3'b100);
    run("wrap_stop", 6'b010000, 16'h0000, 16'h0000, 3'b000);

    // Lap hold: freeze at 0005, release at live 0012.
    run("lap_load", 6'b000010, 16'h0000, 16'h0000, 3'b000);
    run("lap_start", 6'b100000, 16'h0000, 16'h0000, 3'b100);
    for (int i = 1; i <= 50; i++) begin
      logic la;
      la = (i >= 21 && i < 49);
      run("lap", {3'b000, (i == 21 || i == 49), 2'b00}, 16'h0000,
          la ? 16'h0005 : to_bcd(i / 4), {1'b1, la, 1'b0});
    end
    run("lap_stop", 6'b010000, 16'h0000, 16'h0012, 3'b000);

    // Down-count to expiry, then DONE behaviour.
    run("dn_load", 6'b000011, 16'h0002, 16'h0002, 3'b000);
    run("dn_start", 6'b100001, 16'h0000, 16'h0002, 3'b100);
    for (int i = 1; i <= 8; i++)
      run("dn", 6'b000001, 16'h0000, to_bcd(2 - i / 4), (i == 8) ? 3'b001 : 3'b100);
    run("dn_after", 6'b000001, 16'h0000, 16'h0000, 3'b000);
    run("done_start", 6'b100001, 16'h0000, 16'h0000, 3'b000);
    run("done_idle", 6'b000001, 16'h0000, 16'h0000, 3'b000);
    run("done_up", 6'b100000, 16'h0000, 16'h0000, 3'b100);
    for (int i = 1; i <= 4; i++) run("done_run", 6'b000000, 16'h0000, to_bcd(i / 4), 3'b100);
    run("done_stop", 6'b010000, 16'h0000, 16'h0001, 3'b000);

    // Start in down mode at zero expires immediately; load leaves DONE.
    run("z_load", 6'b000010, 16'h0000, 16'h0000, 3'b000);
    run("z_start", 6'b100001, 16'h0000, 16'h0000, 3'b001);
    run("z_idle", 6'b000001, 16'h0000, 16'h0000, 3'b000);
    run("z_inc_done", 6'b001001, 16'h0000, 16'h0000, 3'b000);
    run("z_reload", 6'b000011, 16'h0042, 16'h0042, 3'b000);
    run("z_inc_stop", 6'b001001, 16'h0000, 16'h0041, 3'b000);

    // Asynchronous reset mid-run with lap engaged.
    run("r_load", 6'b000010, 16'h0123, 16'h0123, 3'b000);
    run("r_start", 6'b100000, 16'h0000, 16'h0123, 3'b100);
    run("r_lap", 6'b000100, 16'h0000, 16'h0123, 3'b110);
    run("r_idle", 6'b000000, 16'h0000, 16'h0123, 3'b110);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cntr", 32'(cntr), 32'h0);
    check("async_rst_flags", 32'({running, lap_active, expired}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run("post_rst", 6'b000000, 16'h0000, 16'h0000, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
